// File: rtl/halfsub_pkg.sv
// halfsub_pkg: shared defaults and lane type for the half subtracter.
// Optional borrow counter is enabled with HALFSUB_BORROW_CNT_EN.
package halfsub_pkg;

    localparam int HALFSUB_WIDTH_DEF = 1;
    localparam int HALFSUB_CNT_W_DEF = 8;

    typedef logic [HALFSUB_WIDTH_DEF-1:0] lane_t;

endpackage

// File: rtl/halfsub_bit.sv
// halfsub_bit: stateless one-bit half subtracter cell.
// Computes difference and borrow-out for a single lane.
module halfsub_bit (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    // Pure combinational lane function
    always_comb begin
        d  = a ^ b;
        bo = ~a & b;
    end

endmodule

// File: rtl/halfsubtracter.sv
// halfsubtracter: WIDTH independent registered half-subtracter lanes.
// Define HALFSUB_BORROW_CNT_EN to add the saturating borrow_cnt output.
module halfsubtracter
    import halfsub_pkg::*;
#(
    parameter int WIDTH = HALFSUB_WIDTH_DEF,
    parameter int CNT_W = HALFSUB_CNT_W_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] difference,
    output logic [WIDTH-1:0] borrow,
    input  logic             clk,
    input  logic             rst_n
`ifdef HALFSUB_BORROW_CNT_EN
    ,
    output logic [CNT_W-1:0] borrow_cnt
`endif
);

    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] bo_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        halfsub_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .d  (d_next[i]),
            .bo (bo_next[i])
        );
    end

    // Register lane results; reset clears them without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            difference <= '0;
            borrow     <= '0;
        end else begin
            difference <= d_next;
            borrow     <= bo_next;
        end
    end

`ifdef HALFSUB_BORROW_CNT_EN
    // Count cycles whose registered borrow has any lane set, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_cnt <= '0;
        end else if (|bo_next && (borrow_cnt != {CNT_W{1'b1}})) begin
            borrow_cnt <= borrow_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_halfsubtracter.sv
// tb_halfsubtracter: directed scoreboard bench for halfsubtracter.
// Counter checks are active when HALFSUB_BORROW_CNT_EN is defined.
module tb_halfsubtracter;

    typedef struct {
        logic       d1;
        logic       b1;
        logic [3:0] d4;
        logic [3:0] b4;
        logic [1:0] c;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       a1;
    logic       b1;
    logic       d1;
    logic       bo1;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] d4;
    logic [3:0] bo4;
`ifdef HALFSUB_BORROW_CNT_EN
    logic [1:0] cnt1;
    logic [7:0] cnt4;
`endif

    exp_t q[$];
    int   n_eval;
    int   n_fail;
    logic [1:0] cnt_model;

    // Truth table indexed by {a,b}: {d, bo}
    logic [1:0] tt [4];

    halfsubtracter #(.WIDTH(1), .CNT_W(2)) u1 (
        .a          (a1),
        .b          (b1),
        .difference (d1),
        .borrow     (bo1),
        .clk        (clk),
        .rst_n      (rst_n)
`ifdef HALFSUB_BORROW_CNT_EN
        ,
        .borrow_cnt (cnt1)
`endif
    );

    halfsubtracter #(.WIDTH(4)) u4 (
        .a          (a4),
        .b          (b4),
        .difference (d4),
        .borrow     (bo4),
        .clk        (clk),
        .rst_n      (rst_n)
`ifdef HALFSUB_BORROW_CNT_EN
        ,
        .borrow_cnt (cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".d1"}, {7'd0, d1}, 8'd0);
        chk({tag, ".b1"}, {7'd0, bo1}, 8'd0);
        chk({tag, ".d4"}, {4'd0, d4}, 8'd0);
        chk({tag, ".b4"}, {4'd0, bo4}, 8'd0);
`ifdef HALFSUB_BORROW_CNT_EN
        chk({tag, ".cnt"}, {6'd0, cnt1}, 8'd0);
`endif
    endtask

    // Apply inputs and push the expected post-edge result
    task automatic drive(input logic ai, input logic bi,
                         input logic [3:0] av, input logic [3:0] bv);
        exp_t e;
        logic [1:0] r;
        a1 = ai;
        b1 = bi;
        a4 = av;
        b4 = bv;
        r = tt[{ai, bi}];
        e.d1 = r[1];
        e.b1 = r[0];
        for (int i = 0; i < 4; i++) begin
            r = tt[{av[i], bv[i]}];
            e.d4[i] = r[1];
            e.b4[i] = r[0];
        end
        if (e.b1 && cnt_model != 2'b11) cnt_model = cnt_model + 2'd1;
        e.c = cnt_model;
        q.push_back(e);
    endtask

    // Wait for the capturing edge, then pop and compare
    task automatic sample(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_eval++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".d1"}, {7'd0, d1}, {7'd0, e.d1});
            chk({tag, ".b1"}, {7'd0, bo1}, {7'd0, e.b1});
            chk({tag, ".d4"}, {4'd0, d4}, {4'd0, e.d4});
            chk({tag, ".b4"}, {4'd0, bo4}, {4'd0, e.b4});
`ifdef HALFSUB_BORROW_CNT_EN
            chk({tag, ".cnt"}, {6'd0, cnt1}, {6'd0, e.c});
`endif
        end
    endtask

    initial begin
        n_eval    = 0;
        n_fail    = 0;
        cnt_model = 2'd0;
        tt[0] = 2'b00;
        tt[1] = 2'b11;
        tt[2] = 2'b10;
        tt[3] = 2'b00;
        a1 = 1'b0;
        b1 = 1'b0;
        a4 = 4'd0;
        b4 = 4'd0;
        rst_n = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2 chk_zero("reset");
        @(posedge clk);
        #1 chk_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit, varied 4-bit patterns alongside
        drive(1'b0, 1'b0, 4'b0000, 4'b1111);
        sample("ex00");
        drive(1'b0, 1'b1, 4'b1111, 4'b0000);
        sample("ex01");
        drive(1'b1, 1'b0, 4'b1010, 4'b0110);
        sample("ex10");
        drive(1'b1, 1'b1, 4'b1111, 4'b1111);
        sample("ex11");

        // Lane independence
        drive(1'b1, 1'b0, 4'b0101, 4'b0011);
        sample("lanes");

        // Latency: 00 then 01 changed just after an edge
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        sample("lat00");
        drive(1'b0, 1'b1, 4'b0000, 4'b1000);
        @(negedge clk);
        chk("lat_hold.d1", {7'd0, d1}, 8'd0);
        chk("lat_hold.b1", {7'd0, bo1}, 8'd0);
        #2 a1 = 1'b1;
        #1 a1 = 1'b0;
        chk("lat_glitch.d1", {7'd0, d1}, 8'd0);
        sample("lat01");

        // Async reset between edges with outputs at 1/1
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        @(posedge clk);
        #1 chk_zero("async_hold");
        cnt_model = 2'd0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Borrow counter saturation (CNT_W=2), then hold
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'b0000, 4'b0001);
            sample($sformatf("cnt%0d", i));
        end
        drive(1'b1, 1'b1, 4'b0001, 4'b0001);
        sample("cnt_hold");

`ifdef HALFSUB_BORROW_CNT_EN
        chk("cnt_sat", {6'd0, cnt1}, 8'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_eval, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/halfsubtracter.md
HALFSUBTRACTER -- requirements
Module: halfsubtracter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bit-lanes.
REQ-002 Parameter CNT_W, default 8: width of the borrow event counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port a, input, WIDTH: minuend.
REQ-006 Port b, input, WIDTH: subtrahend.
REQ-007 Port difference, output, WIDTH: registered per-lane difference.
REQ-008 Port borrow, output, WIDTH: registered per-lane borrow-out.
REQ-009 Port borrow_cnt, output, CNT_W: borrow event count; present only with HALFSUB_BORROW_CNT_EN defined.
REQ-010 Port declaration order SHALL be a, b, difference, borrow, clk, rst_n, then borrow_cnt. Existing four-port positional instantiations therefore map a/b/difference/borrow correctly.

Function
REQ-011 For each lane i, the next difference[i] SHALL be a[i] XOR b[i].
REQ-012 For each lane i, the next borrow[i] SHALL be (NOT a[i]) AND b[i].
- Truth table: 00->d0 b0; 01->d1 b1; 10->d1 b0; 11->d0 b0.
REQ-013 Lanes SHALL be fully independent: there is no borrow propagation between lanes.
REQ-014 Latency SHALL be exactly one clk cycle. Inputs are sampled on a rising edge and the result is visible after that edge.
REQ-015 Outputs SHALL hold their value between edges, whatever the input activity between edges.
REQ-016 With the counter enabled, borrow_cnt SHALL increment by 1 on each rising edge where the newly registered borrow has at least one lane set.
REQ-017 borrow_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-018 No handshake exists: every cycle is a valid computation.

Reset
REQ-019 While rst_n is low, difference, borrow and borrow_cnt SHALL be forced to 0 immediately, without waiting for a clock edge.
REQ-020 On the first rising edge after rst_n deasserts, inputs SHALL be sampled normally.
REQ-021 If reset is asserted mid-operation, any pending result SHALL be discarded and outputs SHALL read 0.

Configuration
REQ-022 Macro HALFSUB_BORROW_CNT_EN controls the borrow event counter.
REQ-023 With HALFSUB_BORROW_CNT_EN defined, the borrow_cnt port and the counter logic SHALL be compiled in.
REQ-024 Without HALFSUB_BORROW_CNT_EN, neither the port nor any counter logic SHALL exist. Outputs difference and borrow SHALL behave identically in both builds.

Structure
REQ-025 Shared package halfsub_pkg SHALL hold:
- default constants HALFSUB_WIDTH_DEF=1 and HALFSUB_CNT_W_DEF=8;
- a typedef for the lane vector.
REQ-026 One sub-module, halfsub_bit, SHALL be the combinational one-bit cell with inputs a, b and outputs d, bo. It is instantiated WIDTH times by a generate loop.
REQ-027 The top module SHALL own the output registers and the counter. halfsub_bit SHALL contain no state.

Verification
REQ-028 Exhaustive 1-bit check: with WIDTH=1, apply a,b = 00, 01, 10, 11, one pair per cycle.
- Expected results one cycle later: d/b = 0/0, 1/1, 1/0, 0/0.
REQ-029 Lane independence: with WIDTH=4, apply a=4'b0101, b=4'b0011.
- Expected one cycle later: difference=4'b0110, borrow=4'b0010.
REQ-030 Asynchronous reset: with outputs at d=1, b=1, drive rst_n low between clock edges.
- Expected: both outputs go to 0 before the next edge and stay 0 while rst_n is low.
REQ-031 Latency: change inputs from 00 to 01 just after an edge.
- Expected: outputs remain 0/0 until the next rising edge, then become 1/1.
REQ-032 Counter (macro defined, CNT_W=2): apply a=0, b=1 for 5 cycles.
- Expected: borrow_cnt reads 1, 2, 3, 3, 3 (saturation at 3).
- Then apply a=1, b=1: borrow_cnt holds at 3.
REQ-033 Build without the macro: rerun REQ-028.
- Expected: identical results, and no borrow_cnt port present.
